fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//  Shares the single-port 8-bit frame-buffer RAM between two users:
//   - the VGA display read stream, which has absolute priority;
//   - the image-processing pixel writer, which is buffered and drained during blanking.
//  Sits between the VGA timing controller and the frame-buffer RAM.
//  Owns address generation (y*IMG_W + x) and the front/back buffer swap at frame boundaries.
// PARAMETERS
//  IMG_W         640  active pixels per line; frame stride
//  IMG_H         480  active lines per frame
//  ADDR_W        20   RAM address width; must be >= clog2(2*IMG_W*IMG_H)
//  WR_FIFO_DEPTH 8    write-posting FIFO entries; power of 2, >= 2
// PORTS
//  clock         in   1       pixel clock, 25 MHz
//  reset         in   1       synchronous, active-high
//  disp_active   in   1       1 = timing controller is in the active h AND v region
//  disp_x        in   10      display pixel x to fetch (top level supplies it 2 cycles ahead)
//  disp_y        in   10      display pixel y to fetch
//  disp_vsync    in   1       VSYNC, active low; a 1->0 edge marks the frame boundary
//  color_out     out  8       RRRGGGBB pixel to the timing controller colour input
//  wr_valid      in   1       writer pixel valid
//  wr_ready      out  1       writer pixel accepted when wr_valid & wr_ready
//  wr_x          in   10      writer pixel x
//  wr_y          in   10      writer pixel y
//  wr_data       in   8       writer pixel, RRRGGGBB
//  wr_frame_done in   1       1-cycle pulse: back buffer complete, request swap
//  mem_addr      out  ADDR_W  RAM address
//  mem_we        out  1       RAM write enable
//  mem_wdata     out  8       RAM write data
//  mem_rdata     in   8       RAM read data; 1-cycle synchronous read latency
//  buf_sel       out  1       current front (display) buffer index
//  err_drop      out  1       sticky; set by any accepted out-of-range write
// BEHAVIOUR
//  Reset values: color_out=0, mem_we=0, mem_addr=0, mem_wdata=0, buf_sel=0, err_drop=0,
//   wr_ready=0, FIFO empty, swap_pending=0, state=S_IDLE. wr_ready=0 during reset;
//   it may rise on the first cycle after reset is released.
//  Reset mid-operation discards FIFO contents and any pending swap.
//  Address: base + y*IMG_W + x, where base = 0 (buffer 0) or IMG_W*IMG_H (buffer 1).
//   Multiply by the constant using shift-add; result is truncated to ADDR_W.
//  State machine, evaluated every cycle; priority is S_DISP > S_DRAIN > S_IDLE:
//   S_DISP   when disp_active=1: mem_we=0; mem_addr = front base + disp address.
//   S_DRAIN  when disp_active=0 and the FIFO is non-empty:
//            pop one entry per cycle; mem_we=1 to the back buffer.
//   S_IDLE   otherwise: mem_we=0; mem_addr holds its value.
//  Display path latency = 2 cycles, disp_x/y to color_out (address reg + RAM read).
//   color_out is registered: mem_rdata if a read was issued 2 cycles earlier, else 8'd0.
//   Reads with disp_x>=IMG_W or disp_y>=IMG_H are not issued and give color_out=0.
//  Write posting:
//   wr_ready = !fifo_full & !swap_pending.
//   Push and pop in the same cycle is allowed, and the occupancy is unchanged.
//   A full FIFO never overwrites an entry.
//   Out-of-range writes (wr_x>=IMG_W or wr_y>=IMG_H) are accepted, discarded, and set err_drop.
//  Swap:
//   wr_frame_done sets swap_pending. A wr_valid&wr_ready beat in the same cycle belongs to
//    the completed frame.
//   On a disp_vsync 1->0 edge with swap_pending=1 and FIFO empty: toggle buf_sel and clear
//    swap_pending in the same cycle.
//   If the FIFO is not empty at the edge, the swap waits for the next vsync edge.
//   wr_frame_done while swap_pending=1 has no additional effect.
//  disp_active rising while a drain is in progress: display wins that cycle; the popped
//   entry is not consumed and stays at the FIFO head.
// CONFIGURATION
//  FB_DOUBLE_BUFFER_EN defined:   two buffers, swap logic as above.
//  FB_DOUBLE_BUFFER_EN undefined: single buffer at base 0 for both display and writer.
//   buf_sel is tied to 0, wr_frame_done is ignored, swap_pending is always 0.
//   wr_ready = !fifo_full.
// TESTING
//  1. Release reset with disp_active=0 and no writes
//     -> all outputs at reset values; wr_ready=1 on the next cycle.
//  2. Hold disp_active=1 and write 9 pixels with WR_FIFO_DEPTH=8
//     -> 8 accepted, wr_ready=0, mem_we never asserted.
//     Then drop disp_active -> 8 writes on consecutive cycles, back-buffer addresses correct.
//  3. disp_x=5, disp_y=2, buf_sel=0
//     -> mem_addr=1285 the next cycle; color_out = RAM[1285] 2 cycles after input.
//     disp_x=640 -> color_out=0.
//  4. Pulse wr_frame_done, then a vsync 1->0 edge with FIFO empty
//     -> buf_sel 0->1 on that cycle; wr_ready is 0 from the pulse until the swap.
//  5. Pulse wr_frame_done with 3 entries queued and disp_active=1 until the vsync edge
//     -> no swap at that edge; swap happens at the next edge once the FIFO has drained.
//  6. Write wr_x=700, wr_y=10
//     -> accepted, no RAM write, err_drop=1 until reset.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares a single-port 8-bit frame-buffer RAM between the VGA display read
//   stream (absolute priority) and a buffered image-processing pixel writer
//   whose posted writes are drained while the display is blanking.
//   Generates RAM addresses as base + y*IMG_W + x and, when double buffering
//   is compiled in, swaps front/back buffers on a VSYNC falling edge.
//
// Configuration macro: FB_DOUBLE_BUFFER_EN
//   defined   : two buffers, writer targets the back buffer, swap on vsync.
//   undefined : single buffer at base 0, buf_sel tied 0, wr_frame_done ignored.
//
// Ports
//   clock, reset        pixel clock; synchronous active-high reset
//   disp_active         display is in the active region (read has priority)
//   disp_x, disp_y      display pixel to fetch (2-cycle latency to color_out)
//   disp_vsync          active-low VSYNC; 1->0 edge is the frame boundary
//   color_out           RRRGGGBB pixel, 0 when no read was issued
//   wr_valid/wr_ready   writer handshake; wr_x, wr_y, wr_data pixel payload
//   wr_frame_done       back buffer complete, request a swap
//   mem_addr/we/wdata   RAM request; mem_rdata returns one cycle after mem_addr
//   buf_sel             current front buffer index
//   err_drop            sticky flag for accepted out-of-range writes
module fb_port_arbiter #(
    parameter int unsigned IMG_W         = 640,
    parameter int unsigned IMG_H         = 480,
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned WR_FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_active,
    input  logic [9:0]        disp_x,
    input  logic [9:0]        disp_y,
    input  logic              disp_vsync,
    output logic [7:0]        color_out,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [7:0]        wr_data,
    input  logic              wr_frame_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              buf_sel,
    output logic              err_drop
);

    localparam int unsigned PTR_W = $clog2(WR_FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] FRAME_BASE = ADDR_W'(IMG_W * IMG_H);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(WR_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DISP, S_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] off;
        logic [7:0]        data;
    } entry_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                rd_issue_q, rd_issue_d;
    logic                rd_valid_q, rd_valid_d;
    logic                buf_sel_q, buf_sel_d;
    logic                swap_pending_q, swap_pending_d;
    logic                err_drop_q, err_drop_d;
    logic                wr_ready_q, wr_ready_d;
    logic                vsync_q, vsync_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    entry_t              fifo_q [WR_FIFO_DEPTH];
    entry_t              fifo_d [WR_FIFO_DEPTH];

    logic                push, pop, accept, wr_oor, disp_in_range;
    logic [ADDR_W-1:0]   front_base, back_base;

    // Constant multiply by IMG_W as a sum of shifted copies of y.
    function automatic logic [ADDR_W-1:0] pix_off(input logic [9:0] x, input logic [9:0] y);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int unsigned b = 0; b < 32; b++) begin
            if (IMG_W[b]) acc = acc + (ADDR_W'(y) << b);
        end
        return acc;
    endfunction

`ifndef FB_DOUBLE_BUFFER_EN
    logic unused_frame_done;
    assign unused_frame_done = wr_frame_done;
`endif

    always_comb begin
        state_d        = S_IDLE;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        rd_issue_d     = 1'b0;
        rd_valid_d     = rd_issue_q;
        buf_sel_d      = buf_sel_q;
        swap_pending_d = swap_pending_q;
        err_drop_d     = err_drop_q;
        vsync_d        = disp_vsync;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        fifo_d         = fifo_q;
        push           = 1'b0;
        pop            = 1'b0;

`ifdef FB_DOUBLE_BUFFER_EN
        front_base = buf_sel_q ? FRAME_BASE : '0;
        back_base  = buf_sel_q ? '0 : FRAME_BASE;
`else
        front_base = '0;
        back_base  = '0;
`endif

        disp_in_range = (32'(disp_x) < IMG_W) && (32'(disp_y) < IMG_H);
        wr_oor        = (32'(wr_x) >= IMG_W) || (32'(wr_y) >= IMG_H);
        accept        = wr_valid & wr_ready_q;

        // Display wins outright; an entry is popped only in a cycle the
        // display does not claim, so a rising disp_active leaves the head intact.
        if (disp_active) begin
            state_d = S_DISP;
            if (disp_in_range) begin
                mem_addr_d = front_base + pix_off(disp_x, disp_y);
                rd_issue_d = 1'b1;
            end
        end else if (count_q != '0) begin
            state_d     = S_DRAIN;
            pop         = 1'b1;
            mem_addr_d  = back_base + fifo_q[rd_ptr_q].off;
            mem_wdata_d = fifo_q[rd_ptr_q].data;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end

        if (accept) begin
            if (wr_oor) begin
                err_drop_d = 1'b1;
            end else begin
                push               = 1'b1;
                fifo_d[wr_ptr_q]   = '{off: pix_off(wr_x, wr_y), data: wr_data};
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
        end

        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

`ifdef FB_DOUBLE_BUFFER_EN
        // Emptiness is judged on the occupancy at the start of the edge cycle.
        if (vsync_q && !disp_vsync && swap_pending_q && (count_q == '0)) begin
            buf_sel_d      = ~buf_sel_q;
            swap_pending_d = 1'b0;
        end else if (wr_frame_done) begin
            swap_pending_d = 1'b1;
        end
`else
        buf_sel_d      = 1'b0;
        swap_pending_d = 1'b0;
`endif

        // Registered from next-state so it is low throughout reset.
        wr_ready_d = (count_d != FULL_COUNT) && !swap_pending_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rd_issue_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            buf_sel_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            err_drop_q     <= 1'b0;
            wr_ready_q     <= 1'b0;
            vsync_q        <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rd_issue_q     <= rd_issue_d;
            rd_valid_q     <= rd_valid_d;
            buf_sel_q      <= buf_sel_d;
            swap_pending_q <= swap_pending_d;
            err_drop_q     <= err_drop_d;
            wr_ready_q     <= wr_ready_d;
            vsync_q        <= vsync_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

    // The RAM output register is the second pipeline stage of the read path.
    assign color_out = rd_valid_q ? mem_rdata : '0;
    assign mem_we    = (state_q == S_DRAIN);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_ready  = wr_ready_q;
    assign buf_sel   = buf_sel_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

    localparam int FRAME = 307200;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int WR_BASE0 = FRAME;
`else
    localparam int WR_BASE0 = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        disp_active;
    logic [9:0]  disp_x, disp_y;
    logic        disp_vsync;
    logic [7:0]  color_out;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x, wr_y;
    logic [7:0]  wr_data;
    logic        wr_frame_done;
    logic [19:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        buf_sel;
    logic        err_drop;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    logic [7:0] ram [0:1048575];

    fb_port_arbiter #(
        .IMG_W(640),
        .IMG_H(480),
        .ADDR_W(20),
        .WR_FIFO_DEPTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .disp_active(disp_active),
        .disp_x(disp_x),
        .disp_y(disp_y),
        .disp_vsync(disp_vsync),
        .color_out(color_out),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_x(wr_x),
        .wr_y(wr_y),
        .wr_data(wr_data),
        .wr_frame_done(wr_frame_done),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .buf_sel(buf_sel),
        .err_drop(err_drop)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM, 1-cycle read latency
    always @(posedge clock) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        if (mem_we === 1'b1) we_cnt = we_cnt + 1;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; disp_active = 1'b0; disp_x = '0; disp_y = '0; disp_vsync = 1'b1;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; wr_frame_done = 1'b0;
        repeat (3) step();
        checks++; if (color_out !== 8'd0) begin errors++; $display("FAIL reset_color: got %0h want 0", color_out); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 20'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %0h want 0", mem_wdata); end
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL reset_buf_sel: got %0b want 0", buf_sel); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop: got %0b want 0", err_drop); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %0b want 0", wr_ready); end
        reset = 1'b0;
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready: got %0b want 1", wr_ready); end
    endtask

    task automatic test_fifo_fill;
        int acc = 0;
        disp_active = 1'b1; disp_x = '0; disp_y = '0;
        we_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_x = 10'(i); wr_y = 10'd3; wr_data = 8'(8'h10 + i);
            if (wr_ready === 1'b1) acc++;
            step();
        end
        wr_valid = 1'b0;
        checks++; if (acc !== 8) begin errors++; $display("FAIL fill_accepted: got %0d want 8", acc); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b want 0", wr_ready); end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL fill_no_we: got %0d want 0", we_cnt); end
        disp_active = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL drain_we[%0d]: got %0b want 1", k, mem_we); end
            checks++; if (mem_addr !== 20'(WR_BASE0 + 1920 + k)) begin errors++; $display("FAIL drain_addr[%0d]: got %0d want %0d", k, mem_addr, WR_BASE0 + 1920 + k); end
            checks++; if (mem_wdata !== 8'(8'h10 + k)) begin errors++; $display("FAIL drain_data[%0d]: got %0h want %0h", k, mem_wdata, 8'h10 + k); end
        end
        step();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_end_we: got %0b want 0", mem_we); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL drain_end_ready: got %0b want 1", wr_ready); end
    endtask

    task automatic test_display_read;
        ram[1285] = 8'hA5;
        ram[307199] = 8'h3C;
        disp_active = 1'b1; disp_x = 10'd5; disp_y = 10'd2;
        step();
        checks++; if (mem_addr !== 20'd1285) begin errors++; $display("FAIL disp_addr: got %0d want 1285", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL disp_we: got %0b want 0", mem_we); end
        disp_x = 10'd640;
        step();
        checks++; if (color_out !== 8'hA5) begin errors++; $display("FAIL disp_color: got %0h want a5", color_out); end
        disp_x = 10'd639; disp_y = 10'd479;
        step();
        checks++; if (color_out !== 8'h00) begin errors++; $display("FAIL disp_oor_color: got %0h want 0", color_out); end
        checks++; if (mem_addr !== 20'd307199) begin errors++; $display("FAIL disp_last_addr: got %0d want 307199", mem_addr); end
        disp_active = 1'b0;
        step();
        checks++; if (color_out !== 8'h3C) begin errors++; $display("FAIL disp_last_color: got %0h want 3c", color_out); end
        step();
        checks++; if (color_out !== 8'h00) begin errors++; $display("FAIL disp_idle_color: got %0h want 0", color_out); end
    endtask

`ifdef FB_DOUBLE_BUFFER_EN
    task automatic test_swap;
        disp_active = 1'b0; disp_vsync = 1'b1;
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL swap_ready_pending: got %0b want 0", wr_ready); end
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL swap_buf_early: got %0b want 0", buf_sel); end
        step();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL swap_ready_hold: got %0b want 0", wr_ready); end
        disp_vsync = 1'b0;
        step();
        checks++; if (buf_sel !== 1'b1) begin errors++; $display("FAIL swap_buf: got %0b want 1", buf_sel); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL swap_ready_after: got %0b want 1", wr_ready); end
        disp_vsync = 1'b1;
        step();
    endtask

    task automatic test_swap_deferred;
        disp_active = 1'b1; disp_x = '0; disp_y = '0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_x = 10'(i); wr_y = 10'd1; wr_data = 8'(8'h40 + i);
            wr_frame_done = (i == 2);
            step();
        end
        wr_valid = 1'b0; wr_frame_done = 1'b0;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL defer_ready: got %0b want 0", wr_ready); end
        disp_vsync = 1'b0;
        step();
        checks++; if (buf_sel !== 1'b1) begin errors++; $display("FAIL defer_no_swap: got %0b want 1", buf_sel); end
        disp_vsync = 1'b1; disp_active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL defer_we[%0d]: got %0b want 1", k, mem_we); end
            checks++; if (mem_addr !== 20'(640 + k)) begin errors++; $display("FAIL defer_addr[%0d]: got %0d want %0d", k, mem_addr, 640 + k); end
            checks++; if (mem_wdata !== 8'(8'h40 + k)) begin errors++; $display("FAIL defer_data[%0d]: got %0h want %0h", k, mem_wdata, 8'h40 + k); end
        end
        step();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL defer_end_we: got %0b want 0", mem_we); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL defer_ready_still: got %0b want 0", wr_ready); end
        disp_vsync = 1'b0;
        step();
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL defer_swap: got %0b want 0", buf_sel); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL defer_ready_after: got %0b want 1", wr_ready); end
        disp_vsync = 1'b1;
        step();
    endtask
`else
    task automatic test_single_buffer;
        disp_active = 1'b0; disp_vsync = 1'b1;
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", wr_ready); end
        disp_vsync = 1'b0;
        step();
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL single_buf: got %0b want 0", buf_sel); end
        disp_vsync = 1'b1;
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after: got %0b want 1", wr_ready); end
    endtask
`endif

    task automatic test_oob_write;
        disp_active = 1'b0;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready: got %0b want 1", wr_ready); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL oob_err_before: got %0b want 0", err_drop); end
        wr_valid = 1'b1; wr_x = 10'd700; wr_y = 10'd10; wr_data = 8'hFF;
        we_cnt = 0;
        step();
        wr_valid = 1'b0;
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL oob_err_set: got %0b want 1", err_drop); end
        repeat (4) step();
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL oob_no_write: got %0d want 0", we_cnt); end
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL oob_err_sticky: got %0b want 1", err_drop); end
    endtask

    task automatic test_reset_midop;
        disp_active = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_x = 10'(i); wr_y = 10'd5; wr_data = 8'(i);
`ifdef FB_DOUBLE_BUFFER_EN
            wr_frame_done = (i == 1);
`endif
            step();
        end
        wr_valid = 1'b0; wr_frame_done = 1'b0;
        reset = 1'b1; disp_active = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        we_cnt = 0;
        repeat (4) step();
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL midop_fifo_flushed: got %0d want 0", we_cnt); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL midop_err_clear: got %0b want 0", err_drop); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midop_ready: got %0b want 1", wr_ready); end
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL midop_buf: got %0b want 0", buf_sel); end
    endtask

    initial begin
        test_reset();
        test_fifo_fill();
        test_display_read();
`ifdef FB_DOUBLE_BUFFER_EN
        test_swap();
        test_swap_deferred();
`else
        test_single_buffer();
`endif
        test_oob_write();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
